// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch-side bundle for the instruction-memory responder.
// Carries the request channel, the response channel, the flush strobe and the
// program-load write port. The fetch stage (or bench) uses the master modport;
// the responder uses the slave modport.
interface imem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_Req_Valid;
  logic                  o_Req_Ready;
  logic [DATA_WIDTH-1:0] i_Req_Addr;

  logic                  o_Resp_Valid;
  logic                  i_Resp_Ready;
  logic [DATA_WIDTH-1:0] o_Resp_Instruction;
  logic [DATA_WIDTH-1:0] o_Resp_Addr;
  logic                  o_Resp_Error;

  logic                  i_Flush;

  logic                  i_Wr_En;
  logic [DATA_WIDTH-1:0] i_Wr_Addr;
  logic [DATA_WIDTH-1:0] i_Wr_Data;

  modport master (
    output i_Req_Valid, i_Req_Addr, i_Resp_Ready, i_Flush,
           i_Wr_En, i_Wr_Addr, i_Wr_Data,
    input  o_Req_Ready, o_Resp_Valid, o_Resp_Instruction, o_Resp_Addr,
           o_Resp_Error
  );

  modport slave (
    input  i_Req_Valid, i_Req_Addr, i_Resp_Ready, i_Flush,
           i_Wr_En, i_Wr_Addr, i_Wr_Data,
    output o_Req_Ready, o_Resp_Valid, o_Resp_Instruction, o_Resp_Addr,
           o_Resp_Error
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction memory answering one fetch at a
// time with WAIT_CYCLES wait states, a flush that silently drops the access,
// and a write port for program loading.
//
// Optional feature macro: IMEM_ALIGN_CHECK_EN
//   defined   -> misaligned reads return 0 with error, misaligned writes dropped
//   undefined -> address bits [1:0] are ignored on reads and writes
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; o_Req_Ready high unless flushing
// BUSY   | request latched, counting down wait states before the read
// RESP   | response registers valid, held until handshake or flush
module imem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  imem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [3:0]            r_count;
  logic [DATA_WIDTH-1:0] r_addr;

  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_instr;
  logic [DATA_WIDTH-1:0] r_resp_addr;
  logic                  r_resp_err;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_resp_done;

  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_oor;
  logic                  w_rd_mis;
  logic                  w_rd_err;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_wr_oor;
  logic                  w_wr_mis;
  logic                  w_wr_ok;

  // Handshake qualifiers. A flush blocks acceptance in the same cycle so a
  // request that collides with a taken branch is never started.
  assign w_req_ready = (r_state == S_IDLE) && !bus.i_Flush;
  assign w_accept    = bus.i_Req_Valid && w_req_ready;
  assign w_load      = (r_state == S_BUSY) && !bus.i_Flush && (r_count == 4'd0);
  assign w_resp_done = (r_state == S_RESP) && (bus.i_Flush || bus.i_Resp_Ready);

  // Read-side address decode works from the latched request address.
  assign w_rd_idx  = r_addr[IDX_W+1:2];
  assign w_rd_oor  = |r_addr[DATA_WIDTH-1:IDX_W+2];
  assign w_rd_data = r_mem[w_rd_idx];

  assign w_wr_idx  = bus.i_Wr_Addr[IDX_W+1:2];
  assign w_wr_oor  = |bus.i_Wr_Addr[DATA_WIDTH-1:IDX_W+2];

`ifdef IMEM_ALIGN_CHECK_EN
  assign w_rd_mis = |r_addr[1:0];
  assign w_wr_mis = |bus.i_Wr_Addr[1:0];
`else
  // Byte-offset bits of the write address carry no meaning in this build.
  logic w_unused_wr_lsb;
  assign w_unused_wr_lsb = ^bus.i_Wr_Addr[1:0];
  assign w_rd_mis = 1'b0;
  assign w_wr_mis = 1'b0;
`endif

  assign w_rd_err = w_rd_oor || w_rd_mis;
  assign w_wr_ok  = bus.i_Wr_En && !w_wr_oor && !w_wr_mis;

  // Sequencer: latch request, count down wait states, present, release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.i_Req_Addr;
            r_count <= 4'(WAIT_CYCLES);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.i_Flush) begin
            r_state <= S_IDLE;
          end else if (r_count == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        S_RESP: begin
          if (w_resp_done) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Response registers: loaded once at the end of the wait, held while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_instr <= '0;
      r_resp_addr  <= '0;
      r_resp_err   <= 1'b0;
    end else if (w_load) begin
      r_resp_valid <= 1'b1;
      r_resp_instr <= w_rd_err ? '0 : w_rd_data;
      r_resp_addr  <= r_addr;
      r_resp_err   <= w_rd_err;
    end else if (w_resp_done) begin
      r_resp_valid <= 1'b0;
    end
  end

  // Instruction array; not reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_idx] <= bus.i_Wr_Data;
    end
  end

  assign bus.o_Req_Ready        = w_req_ready;
  assign bus.o_Resp_Valid       = r_resp_valid;
  assign bus.o_Resp_Instruction = r_resp_instr;
  assign bus.o_Resp_Addr        = r_resp_addr;
  assign bus.o_Resp_Error       = r_resp_err;

endmodule
